// File: rtl/s1269_host_if.sv
// rtl/s1269_host_if.sv - request/response handshake bundle between the system controller and s1269_host
interface s1269_host_if;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       req_clr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_hi;
    logic [7:0] rsp_lo;
    logic       rsp_timeout;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_clr, rsp_ready,
        output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_timeout
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_clr, rsp_ready,
        input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_timeout
    );
endinterface

// File: rtl/s1269_host.sv
// rtl/s1269_host.sv - bus-side initiator sequencing loads, execute, wait and read-back on the s1269 datapath
module s1269_host #(
    parameter int TIMEOUT = 64,
    parameter int CW      = 8
) (
    input  logic       clock,
    input  logic       reset,
    s1269_host_if.slave bus,
    output logic [2:0] INS,
    output logic       LDAcc,
    output logic       LDMQ,
    output logic       LDDR,
    output logic       STAcc,
    output logic       STMQ,
    output logic       STDR,
    output logic       TESTMODE,
    output logic [7:0] inBUS,
    input  logic [7:0] outBUS,
    input  logic       RDY
);
    typedef enum logic [3:0] {
        S_IDLE, S_LD_DR, S_LD_MQ, S_LD_ACC, S_EXEC, S_WAIT, S_RD_ACC, S_RD_MQ, S_RESP
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [7:0]    a_q, a_d, b_q, b_d;
    logic          clr_q, clr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    hi_q, hi_d, lo_q, lo_d;
    logic          tmo_q, tmo_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            clr_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            clr_q   <= clr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        clr_d   = clr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    clr_d   = bus.req_clr;
                    hi_d    = '0;
                    lo_d    = '0;
                    tmo_d   = 1'b0;
                    state_d = S_LD_DR;
                end
            end
            S_LD_DR:  state_d = S_LD_MQ;
            S_LD_MQ:  state_d = clr_q ? S_LD_ACC : S_EXEC;
            S_LD_ACC: state_d = S_EXEC;
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // RDY wins even on the final permitted wait cycle
                if (RDY) begin
                    state_d = S_RD_ACC;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    hi_d    = '0;
                    lo_d    = '0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RD_ACC: begin
                hi_d    = outBUS;
                state_d = S_RD_MQ;
            end
            S_RD_MQ: begin
                lo_d    = outBUS;
                state_d = S_RESP;
            end
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath-facing outputs decode only flopped state, never the request inputs
    always_comb begin
        INS   = '0;
        LDAcc = 1'b0;
        LDMQ  = 1'b0;
        LDDR  = 1'b0;
        STAcc = 1'b0;
        STMQ  = 1'b0;
        inBUS = '0;
        unique case (state_q)
            S_LD_DR: begin
                LDDR  = 1'b1;
                inBUS = a_q;
            end
            S_LD_MQ: begin
                LDMQ  = 1'b1;
                inBUS = b_q;
            end
            S_LD_ACC: LDAcc = 1'b1;
            S_EXEC, S_WAIT: INS = op_q;
            S_RD_ACC: begin
                INS   = op_q;
                STAcc = 1'b1;
            end
            S_RD_MQ: begin
                INS  = op_q;
                STMQ = 1'b1;
            end
            default: ;
        endcase
    end

    assign STDR            = 1'b0;
    assign TESTMODE        = 1'b0;
    assign bus.req_ready   = (state_q == S_IDLE);
    assign bus.rsp_valid   = (state_q == S_RESP);
    assign bus.rsp_hi      = hi_q;
    assign bus.rsp_lo      = lo_q;
    assign bus.rsp_timeout = tmo_q;
endmodule
